// File: rtl/bnn_layer_engine_if.sv
// Operand-beat and output-word handshake bundle for bnn_layer_engine.
//   in_valid/in_ready   : operand beat handshake (image, weight, th)
//   out_valid/out_ready : packed output word handshake (out_data)
// slave = engine side, master = producer/consumer side.
interface bnn_layer_engine_if #(
    parameter int unsigned WL = 112,
    parameter int unsigned AW = 11
);
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] image;
    logic [WL-1:0] weight;
    logic [AW-1:0] th;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] out_data;

    modport slave (
        input  in_valid, image, weight, th, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, image, weight, th, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bnn_layer_engine.sv
// Binary neural network layer engine: XNOR-popcount accumulation over
// operand beats, then either threshold + OR-pool + pack into output words
// (mode 0) or argmax over neuron sums (mode 1).
// Ports:
//   iCLK, iRSTn                 clock, async active-low reset
//   iCLR                        synchronous clear to IDLE
//   iSTART, iMODE, iNPART,
//   iNOUT, iPOOL, iNWORDS       run start and configuration (latched at start)
//   bus                         beat/word handshakes (bnn_layer_engine_if.slave)
//   oCLASS, oMAXVAL             argmax result
//   oBUSY, oDONE                status, one-cycle completion pulse
module bnn_layer_engine #(
    parameter int unsigned WL = 112,
    parameter int unsigned PW = 7,
    parameter int unsigned AW = 11
) (
    input  logic             iCLK,
    input  logic             iRSTn,
    input  logic             iCLR,
    input  logic             iSTART,
    input  logic             iMODE,
    input  logic [3:0]       iNPART,
    input  logic [6:0]       iNOUT,
    input  logic [2:0]       iPOOL,
    input  logic [8:0]       iNWORDS,
    bnn_layer_engine_if.slave bus,
    output logic [6:0]       oCLASS,
    output logic [AW-1:0]    oMAXVAL,
    output logic             oBUSY,
    output logic             oDONE
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT, S_DONE} state_t;

    state_t        state;
    logic          mode_q;
    logic [3:0]    npart_q;
    logic [6:0]    nout_q;
    logic [2:0]    pool_q;
    logic [8:0]    nwords_q;
    logic [3:0]    beat_cnt;
    logic [6:0]    neuron_cnt;
    logic [2:0]    pass_cnt;
    logic [8:0]    word_cnt;
    logic [AW-1:0] acc;
    logic [WL-1:0] pool_reg;

    logic [WL-1:0] match;
    logic [PW-1:0] pc;
    logic [AW-1:0] sum;
    logic          beat_fire;
    logic          out_fire;
    logic          last_beat;
    logic          last_neuron;
    logic          last_pass;
    logic          th_bit;
    logic [WL-1:0] pool_next;
    logic [8:0]    word_inc;

    // XNOR popcount of the current beat
    assign match = ~(bus.image ^ bus.weight);
    always_comb begin
        pc = '0;
        for (int i = 0; i < int'(WL); i++) begin
            pc = pc + PW'(match[i]);
        end
    end

    assign sum         = acc + AW'(pc);
    assign beat_fire   = bus.in_valid && bus.in_ready && (state == S_RUN);
    assign out_fire    = bus.out_valid && bus.out_ready;
    assign last_beat   = (beat_cnt == 4'(npart_q - 4'd1));
    assign last_neuron = (neuron_cnt == 7'(nout_q - 7'd1));
    assign last_pass   = (pass_cnt == 3'(pool_q - 3'd1));
    assign th_bit      = (sum >= bus.th);
    assign pool_next   = pool_reg | (th_bit ? (WL'(1) << neuron_cnt) : '0);
    assign word_inc    = 9'(word_cnt + 9'd1);

    // Control FSM with all outputs registered
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state         <= S_IDLE;
            mode_q        <= 1'b0;
            npart_q       <= '0;
            nout_q        <= '0;
            pool_q        <= '0;
            nwords_q      <= '0;
            beat_cnt      <= '0;
            neuron_cnt    <= '0;
            pass_cnt      <= '0;
            word_cnt      <= '0;
            acc           <= '0;
            pool_reg      <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            oCLASS        <= '0;
            oMAXVAL       <= '0;
            oBUSY         <= 1'b0;
            oDONE         <= 1'b0;
        end else if (iCLR) begin
            state         <= S_IDLE;
            beat_cnt      <= '0;
            neuron_cnt    <= '0;
            pass_cnt      <= '0;
            word_cnt      <= '0;
            acc           <= '0;
            pool_reg      <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            oCLASS        <= '0;
            oMAXVAL       <= '0;
            oBUSY         <= 1'b0;
            oDONE         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iSTART) begin
                        mode_q       <= iMODE;
                        npart_q      <= iNPART;
                        nout_q       <= iNOUT;
                        pool_q       <= iPOOL;
                        nwords_q     <= iNWORDS;
                        beat_cnt     <= '0;
                        neuron_cnt   <= '0;
                        pass_cnt     <= '0;
                        word_cnt     <= '0;
                        acc          <= '0;
                        pool_reg     <= '0;
                        oCLASS       <= '0;
                        oMAXVAL      <= '0;
                        oBUSY        <= 1'b1;
                        bus.in_ready <= 1'b1;
                        state        <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (beat_fire) begin
                        if (!last_beat) begin
                            acc      <= sum;
                            beat_cnt <= 4'(beat_cnt + 4'd1);
                        end else begin
                            acc        <= '0;
                            beat_cnt   <= '0;
                            neuron_cnt <= last_neuron ? 7'd0 : 7'(neuron_cnt + 7'd1);
                            if (!mode_q) begin
                                pool_reg <= pool_next;
                                if (last_neuron) begin
                                    pass_cnt <= last_pass ? 3'd0 : 3'(pass_cnt + 3'd1);
                                end
                                if (last_neuron && last_pass) begin
                                    bus.out_data  <= pool_next;
                                    bus.out_valid <= 1'b1;
                                    bus.in_ready  <= 1'b0;
                                    state         <= S_OUT;
                                end
                            end else begin
                                // Strict compare keeps the lowest index on ties
                                if (neuron_cnt == 7'd0 || sum > oMAXVAL) begin
                                    oMAXVAL <= sum;
                                    oCLASS  <= neuron_cnt;
                                end
                                if (last_neuron) begin
                                    bus.in_ready <= 1'b0;
                                    oDONE        <= 1'b1;
                                    state        <= S_DONE;
                                end
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (out_fire) begin
                        bus.out_valid <= 1'b0;
                        pool_reg      <= '0;
                        word_cnt      <= word_inc;
                        if (word_inc < nwords_q) begin
                            bus.in_ready <= 1'b1;
                            state        <= S_RUN;
                        end else begin
                            oDONE <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    oDONE <= 1'b0;
                    oBUSY <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_layer_engine.sv
// Directed self-checking bench for bnn_layer_engine.
module tb_bnn_layer_engine;
    localparam int unsigned WL = 112;
    localparam int unsigned AW = 11;

    logic          iCLK = 1'b0;
    logic          iRSTn = 1'b0;
    logic          iCLR = 1'b0;
    logic          iSTART = 1'b0;
    logic          iMODE = 1'b0;
    logic [3:0]    iNPART = 4'd1;
    logic [6:0]    iNOUT = 7'd1;
    logic [2:0]    iPOOL = 3'd1;
    logic [8:0]    iNWORDS = 9'd1;
    logic [6:0]    oCLASS;
    logic [AW-1:0] oMAXVAL;
    logic          oBUSY;
    logic          oDONE;

    int errors = 0;
    int checks = 0;

    bnn_layer_engine_if #(.WL(WL), .AW(AW)) bus ();

    bnn_layer_engine #(.WL(WL), .PW(7), .AW(AW)) dut (
        .iCLK    (iCLK),
        .iRSTn   (iRSTn),
        .iCLR    (iCLR),
        .iSTART  (iSTART),
        .iMODE   (iMODE),
        .iNPART  (iNPART),
        .iNOUT   (iNOUT),
        .iPOOL   (iPOOL),
        .iNWORDS (iNWORDS),
        .bus     (bus),
        .oCLASS  (oCLASS),
        .oMAXVAL (oMAXVAL),
        .oBUSY   (oBUSY),
        .oDONE   (oDONE)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Weight with WL-pc ones against an all-zero image gives popcount pc
    function automatic logic [WL-1:0] w_for_pc(input int pc);
        logic [WL-1:0] w;
        w = '0;
        for (int i = 0; i < int'(WL) - pc; i++) w[i] = 1'b1;
        return w;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic start_run(input logic mode, input int npart, input int nout,
                             input int pool, input int nwords);
        iMODE   = mode;
        iNPART  = 4'(npart);
        iNOUT   = 7'(nout);
        iPOOL   = 3'(pool);
        iNWORDS = 9'(nwords);
        iSTART  = 1'b1;
        tick();
        iSTART  = 1'b0;
    endtask

    task automatic send_beat(input int pc, input int th);
        int n;
        n = 0;
        bus.image    = '0;
        bus.weight   = w_for_pc(pc);
        bus.th       = AW'(th);
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready=%b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    // NPART=1, NOUT=3, th=60, pcs 112/0/60 -> word 3'b101
    task automatic run_basic(input string tag);
        logic [WL-1:0] exp_data;
        exp_data = WL'(5);
        start_run(1'b0, 1, 3, 1, 1);
        checks++;
        if (oBUSY !== 1'b1) begin errors++; $display("FAIL %s busy_run: got %b required 1", tag, oBUSY); end
        send_beat(112, 60);
        send_beat(0, 60);
        send_beat(60, 60);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid: got %b required 1", tag, bus.out_valid); end
        checks++;
        if (bus.out_data !== exp_data) begin errors++; $display("FAIL %s out_data: got %h required %h", tag, bus.out_data, exp_data); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_out: got %b required 0", tag, bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (oDONE !== 1'b1) begin errors++; $display("FAIL %s done_pulse: got %b required 1", tag, oDONE); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid_drop: got %b required 0", tag, bus.out_valid); end
        tick();
        checks++;
        if (oDONE !== 1'b0 || oBUSY !== 1'b0) begin errors++; $display("FAIL %s idle_after_done: got done=%b busy=%b required 0 0", tag, oDONE, oBUSY); end
    endtask

    task automatic test_reset();
        iRSTn = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.image     = '0;
        bus.weight    = '0;
        bus.th        = '0;
        tick();
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0)
            begin errors++; $display("FAIL reset_bus: got rdy=%b vld=%b data=%h required 0", bus.in_ready, bus.out_valid, bus.out_data); end
        checks++;
        if (oCLASS !== 7'd0 || oMAXVAL !== '0 || oBUSY !== 1'b0 || oDONE !== 1'b0)
            begin errors++; $display("FAIL reset_status: got class=%0d max=%0d busy=%b done=%b required 0", oCLASS, oMAXVAL, oBUSY, oDONE); end
        iRSTn = 1'b1;
        tick();
    endtask

    task automatic test_threshold();
        run_basic("threshold");
    endtask

    // Pooling over 4 passes, two words, with backpressure on word 1
    task automatic test_pool_backpressure();
        logic [WL-1:0] exp1;
        logic [WL-1:0] exp2;
        exp1 = WL'(1);
        exp2 = WL'(2);
        start_run(1'b0, 9, 2, 4, 2);
        for (int p = 0; p < 4; p++)
            for (int n = 0; n < 2; n++)
                for (int b = 0; b < 9; b++)
                    send_beat(50, (b < 8) ? 0 : ((p == 2 && n == 0) ? 450 : 451));
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp1)
            begin errors++; $display("FAIL pool_word1: got vld=%b data=%h required 1 %h", bus.out_valid, bus.out_data, exp1); end
        bus.image    = '0;
        bus.weight   = '0;
        bus.th       = '0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp1)
                begin errors++; $display("FAIL hold_data cycle %0d: got vld=%b data=%h required 1 %h", c, bus.out_valid, bus.out_data, exp1); end
            checks++;
            if (bus.in_ready !== 1'b0)
                begin errors++; $display("FAIL hold_in_ready cycle %0d: got %b required 0", c, bus.in_ready); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || oDONE !== 1'b0)
            begin errors++; $display("FAIL word1_handshake: got vld=%b rdy=%b done=%b required 0 1 0", bus.out_valid, bus.in_ready, oDONE); end
        for (int p = 0; p < 4; p++)
            for (int n = 0; n < 2; n++)
                for (int b = 0; b < 9; b++)
                    send_beat(50, (b < 8) ? 0 : ((p == 0 && n == 1) ? 0 : 451));
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp2)
            begin errors++; $display("FAIL pool_word2: got vld=%b data=%h required 1 %h", bus.out_valid, bus.out_data, exp2); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (oDONE !== 1'b1) begin errors++; $display("FAIL pool_done: got %b required 1", oDONE); end
        tick();
    endtask

    task automatic test_argmax();
        int sums [13];
        sums = '{10, 50, 50, 20, 7, 0, 49, 3, 30, 45, 12, 1, 50};
        start_run(1'b1, 6, 13, 1, 1);
        for (int n = 0; n < 13; n++) begin
            send_beat(sums[n], 1000);
            for (int b = 1; b < 6; b++) send_beat(0, 1000);
        end
        checks++;
        if (oDONE !== 1'b1) begin errors++; $display("FAIL argmax_done: got %b required 1", oDONE); end
        checks++;
        if (oCLASS !== 7'd1) begin errors++; $display("FAIL argmax_class: got %0d required 1", oCLASS); end
        checks++;
        if (oMAXVAL !== AW'(50)) begin errors++; $display("FAIL argmax_maxval: got %0d required 50", oMAXVAL); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL argmax_no_word: got %b required 0", bus.out_valid); end
        tick();
        checks++;
        if (oDONE !== 1'b0 || oBUSY !== 1'b0) begin errors++; $display("FAIL argmax_single_pulse: got done=%b busy=%b required 0 0", oDONE, oBUSY); end
        checks++;
        if (oCLASS !== 7'd1 || oMAXVAL !== AW'(50)) begin errors++; $display("FAIL argmax_hold: got %0d/%0d required 1/50", oCLASS, oMAXVAL); end
        tick();
    endtask

    task automatic test_clear();
        start_run(1'b0, 2, 3, 1, 1);
        checks++;
        if (oCLASS !== 7'd0 || oMAXVAL !== '0) begin errors++; $display("FAIL start_clears_result: got %0d/%0d required 0/0", oCLASS, oMAXVAL); end
        send_beat(112, 0);
        send_beat(112, 0);
        send_beat(100, 0);
        iCLR = 1'b1;
        tick();
        iCLR = 1'b0;
        checks++;
        if (oBUSY !== 1'b0 || oDONE !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL clear_idle: got busy=%b done=%b rdy=%b vld=%b required 0", oBUSY, oDONE, bus.in_ready, bus.out_valid); end
        bus.in_valid = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || oDONE !== 1'b0) begin errors++; $display("FAIL clear_stays_idle: got rdy=%b done=%b required 0 0", bus.in_ready, oDONE); end
        bus.in_valid = 1'b0;
        run_basic("after_clear");
    endtask

    task automatic test_reset_mid_out();
        start_run(1'b0, 1, 3, 1, 1);
        send_beat(112, 60);
        send_beat(0, 60);
        send_beat(60, 60);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_out: got %b required 1", bus.out_valid); end
        iRSTn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || oBUSY !== 1'b0 || bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL async_reset: got vld=%b data=%h busy=%b rdy=%b required 0", bus.out_valid, bus.out_data, oBUSY, bus.in_ready); end
        tick();
        iRSTn = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (oDONE !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
                begin errors++; $display("FAIL post_reset_idle cycle %0d: got done=%b vld=%b rdy=%b required 0", c, oDONE, bus.out_valid, bus.in_ready); end
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        run_basic("after_reset");
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_pool_backpressure();
        test_argmax();
        test_clear();
        test_reset_mid_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
